sha256_job_scheduler: RTL and testbench

Front-end controller that queues hash jobs and sequences a single simplified_sha256 core through them one at a time. Each job is a message address, a hash address and a tag. The block launches the core and waits for its done signal. It recovers the core by resetting it if the core hangs, and returns a tagged completion record with status. It sits between the system command path and the core's start/done/address pins; it does not touch the memory bus.

---
 rtl/sha256_sched_pkg.sv | 25 ++
 rtl/sched_job_fifo.sv | 57 +++++
 rtl/sha256_job_scheduler.sv | 173 +++++++++++++++++
 tb/tb_sha256_job_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_sched_pkg.sv
// Shared types for the SHA-256 job scheduler: FSM states, completion status codes
// and the packed job record that is stored in the job queue.
package sha256_sched_pkg;

  localparam int JOB_ADDR_W = 16;
  localparam int JOB_TAG_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RECOVER,
    S_COMPLETE
  } sched_state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;

  typedef struct packed {
    logic [JOB_ADDR_W-1:0] msg_addr;
    logic [JOB_ADDR_W-1:0] hash_addr;
    logic [JOB_TAG_W-1:0]  tag;
  } job_t;

endpackage

// File: rtl/sched_job_fifo.sv
// Synchronous show-ahead FIFO for queued jobs; the head entry is readable
// combinationally so the scheduler can pop and latch it in the same cycle.
module sched_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; validity is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (do_push && !do_pop) begin
        count_reg <= count_reg + (PW+1)'(1);
      end else if (!do_push && do_pop) begin
        count_reg <= count_reg - (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/sha256_job_scheduler.sv
// Queues hash jobs and runs them one at a time through a single SHA-256 core,
// resetting the core when it hangs and returning a tagged completion record.
module sha256_job_scheduler
  import sha256_sched_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int TAG_W          = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int RST_CYCLES     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_msg_addr,
  input  logic [ADDR_W-1:0] job_hash_addr,
  input  logic [TAG_W-1:0]  job_tag,
  output logic              core_start,
  output logic [ADDR_W-1:0] core_input_addr,
  output logic [ADDR_W-1:0] core_hash_addr,
  output logic              core_rst_n,
  input  logic              core_done,
  output logic              cmp_valid,
  input  logic              cmp_ready,
  output logic [TAG_W-1:0]  cmp_tag,
  output logic [1:0]        cmp_status,
  output logic [15:0]       jobs_done_count,
  output logic [31:0]       busy_cycles,
  output logic              idle
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam int RC_W  = $clog2(RST_CYCLES + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  sched_state_t      state_reg;
  logic [TMR_W-1:0]  timer_reg;
  logic [RC_W-1:0]   rst_cnt_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic              run_reg;
  logic              core_start_reg;
  logic              core_rst_n_reg;
  logic [ADDR_W-1:0] core_input_addr_reg;
  logic [ADDR_W-1:0] core_hash_addr_reg;
  logic              cmp_valid_reg;
  logic [TAG_W-1:0]  cmp_tag_reg;
  logic [1:0]        cmp_status_reg;
  logic [15:0]       jobs_done_reg;
  logic [31:0]       busy_cycles_reg;

  job_t              job_in;
  job_t              job_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_push;
  logic              fifo_pop;

  // Job record fields are sized by the package; ports are cast in and out.
  assign job_in.msg_addr  = JOB_ADDR_W'(job_msg_addr);
  assign job_in.hash_addr = JOB_ADDR_W'(job_hash_addr);
  assign job_in.tag       = JOB_TAG_W'(job_tag);

  assign job_ready = run_reg && !fifo_full;
  assign fifo_push = job_valid && job_ready;
  assign fifo_pop  = (state_reg == S_IDLE) && !fifo_empty;
  assign idle      = (state_reg == S_IDLE) && (fifo_count == '0);

  sched_job_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(job_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (job_in),
    .dout    (job_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg           <= S_IDLE;
      timer_reg           <= '0;
      rst_cnt_reg         <= '0;
      tag_reg             <= '0;
      run_reg             <= 1'b0;
      core_start_reg      <= 1'b0;
      core_rst_n_reg      <= 1'b0;
      core_input_addr_reg <= '0;
      core_hash_addr_reg  <= '0;
      cmp_valid_reg       <= 1'b0;
      cmp_tag_reg         <= '0;
      cmp_status_reg      <= ST_OK;
      jobs_done_reg       <= '0;
      busy_cycles_reg     <= '0;
    end else begin
      run_reg        <= 1'b1;
      core_start_reg <= 1'b0;
      core_rst_n_reg <= 1'b1;
      if (state_reg != S_IDLE && busy_cycles_reg != '1) begin
        busy_cycles_reg <= busy_cycles_reg + 32'd1;
      end
      case (state_reg)
        S_IDLE: begin
          if (!fifo_empty) begin
            core_input_addr_reg <= ADDR_W'(job_head.msg_addr);
            core_hash_addr_reg  <= ADDR_W'(job_head.hash_addr);
            tag_reg             <= TAG_W'(job_head.tag);
            core_start_reg      <= 1'b1;
            state_reg           <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          timer_reg <= '0;
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          // timer_reg==0 marks the first WAIT cycle, where a done left over
          // from the previous job may still be high.
          if (timer_reg != '0 && core_done) begin
            cmp_valid_reg  <= 1'b1;
            cmp_tag_reg    <= tag_reg;
            cmp_status_reg <= ST_OK;
            state_reg      <= S_COMPLETE;
          end else if (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            core_rst_n_reg <= 1'b0;
            rst_cnt_reg    <= '0;
            state_reg      <= S_RECOVER;
          end else begin
            timer_reg <= timer_reg + TMR_W'(1);
          end
        end
        S_RECOVER: begin
          if (rst_cnt_reg == RC_W'(RST_CYCLES - 1)) begin
            cmp_valid_reg  <= 1'b1;
            cmp_tag_reg    <= tag_reg;
            cmp_status_reg <= ST_TIMEOUT;
            state_reg      <= S_COMPLETE;
          end else begin
            core_rst_n_reg <= 1'b0;
            rst_cnt_reg    <= rst_cnt_reg + RC_W'(1);
          end
        end
        S_COMPLETE: begin
          if (cmp_ready) begin
            cmp_valid_reg <= 1'b0;
            state_reg     <= S_IDLE;
            if (jobs_done_reg != 16'hFFFF) begin
              jobs_done_reg <= jobs_done_reg + 16'd1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign core_start      = core_start_reg;
  assign core_rst_n      = core_rst_n_reg;
  assign core_input_addr = core_input_addr_reg;
  assign core_hash_addr  = core_hash_addr_reg;
  assign cmp_valid       = cmp_valid_reg;
  assign cmp_tag         = cmp_tag_reg;
  assign cmp_status      = cmp_status_reg;
  assign jobs_done_count = jobs_done_reg;
  assign busy_cycles     = busy_cycles_reg;

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Directed bench for sha256_job_scheduler; the core is stubbed by driving
// core_done from the stimulus sequence.
module tb_sha256_job_scheduler;

  localparam int ADDR_W  = 16;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 400;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              job_valid;
  logic              job_ready;
  logic [ADDR_W-1:0] job_msg_addr;
  logic [ADDR_W-1:0] job_hash_addr;
  logic [TAG_W-1:0]  job_tag;
  logic              core_start;
  logic [ADDR_W-1:0] core_input_addr;
  logic [ADDR_W-1:0] core_hash_addr;
  logic              core_rst_n;
  logic              core_done;
  logic              cmp_valid;
  logic              cmp_ready;
  logic [TAG_W-1:0]  cmp_tag;
  logic [1:0]        cmp_status;
  logic [15:0]       jobs_done_count;
  logic [31:0]       busy_cycles;
  logic              idle;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  sha256_job_scheduler #(
    .ADDR_W         (ADDR_W),
    .TAG_W          (TAG_W),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TIMEOUT),
    .RST_CYCLES     (2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_msg_addr    (job_msg_addr),
    .job_hash_addr   (job_hash_addr),
    .job_tag         (job_tag),
    .core_start      (core_start),
    .core_input_addr (core_input_addr),
    .core_hash_addr  (core_hash_addr),
    .core_rst_n      (core_rst_n),
    .core_done       (core_done),
    .cmp_valid       (cmp_valid),
    .cmp_ready       (cmp_ready),
    .cmp_tag         (cmp_tag),
    .cmp_status      (cmp_status),
    .jobs_done_count (jobs_done_count),
    .busy_cycles     (busy_cycles),
    .idle            (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (core_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int tag, input int msg, input int hash);
    job_tag       = TAG_W'(tag);
    job_msg_addr  = ADDR_W'(msg);
    job_hash_addr = ADDR_W'(hash);
    job_valid     = 1'b1;
    tick();
    job_valid     = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (core_start === 1'b1) found = 1'b1;
      else tick();
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_cmp(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (cmp_valid === 1'b1) found = 1'b1;
      else tick();
    end
    check(tag, 32'(found), 32'd1);
    $display("completion tag=%0d status=%0d done_count=%0d", cmp_tag, cmp_status, jobs_done_count);
  endtask

  task automatic handshake;
    cmp_ready = 1'b1;
    tick();
    cmp_ready = 1'b0;
  endtask

  initial begin
    int s0;
    int bad;
    reset_n = 1'b0; job_valid = 1'b0; job_msg_addr = '0; job_hash_addr = '0;
    job_tag = '0; core_done = 1'b0; cmp_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_core_rst_n", 32'(core_rst_n), 0);
    check("rst_job_ready", 32'(job_ready), 0);
    check("rst_cmp_valid", 32'(cmp_valid), 0);
    check("rst_core_start", 32'(core_start), 0);
    reset_n = 1'b1;
    tick();
    check("rel_core_rst_n", 32'(core_rst_n), 1);
    check("rel_job_ready", 32'(job_ready), 1);
    check("rel_idle", 32'(idle), 1);
    check("rel_busy", busy_cycles, 0);

    // Single job, done 300 cycles after start
    push(3, 0, 1000);
    check("t1_no_start_yet", 32'(core_start), 0);
    tick();
    check("t1_start", 32'(core_start), 1);
    check("t1_in_addr", 32'(core_input_addr), 0);
    check("t1_hash_addr", 32'(core_hash_addr), 1000);
    tick();
    check("t1_start_one_cycle", 32'(core_start), 0);
    bad = 0;
    for (int i = 0; i < 298; i++) begin
      tick();
      if (core_input_addr !== 16'd0 || core_hash_addr !== 16'd1000 || cmp_valid !== 1'b0) bad++;
    end
    check("t1_addr_stable", 32'(bad), 0);
    core_done = 1'b1;
    tick();
    check("t1_cmp_valid", 32'(cmp_valid), 1);
    check("t1_cmp_tag", 32'(cmp_tag), 3);
    check("t1_cmp_status", 32'(cmp_status), 0);
    $display("completion tag=%0d status=%0d", cmp_tag, cmp_status);
    handshake();
    core_done = 1'b0;
    check("t1_cmp_drop", 32'(cmp_valid), 0);
    check("t1_done_count", 32'(jobs_done_count), 1);
    check("t1_busy", busy_cycles, 301);
    check("t1_starts", 32'(start_cnt), 1);
    check("t1_idle", 32'(idle), 1);

    // Queue full: five jobs while the core stalls, sixth offer blocked
    for (int i = 0; i < 5; i++) begin
      check("t2_ready_before_push", 32'(job_ready), 1);
      job_tag = TAG_W'(i); job_msg_addr = ADDR_W'(i * 16); job_hash_addr = ADDR_W'(i * 16 + 8);
      job_valid = 1'b1;
      tick();
    end
    check("t2_full", 32'(job_ready), 0);
    job_tag = 4'd9;
    repeat (3) tick();
    job_valid = 1'b0;
    check("t2_still_full", 32'(job_ready), 0);
    for (int j = 0; j < 5; j++) begin
      if (j != 0) begin
        wait_start("t2_start");
        check("t2_in_addr", 32'(core_input_addr), 32'(j * 16));
        repeat (3) tick();
      end
      core_done = 1'b1;
      wait_cmp("t2_cmp");
      check("t2_tag", 32'(cmp_tag), 32'(j));
      check("t2_status", 32'(cmp_status), 0);
      handshake();
      core_done = 1'b0;
    end
    check("t2_idle", 32'(idle), 1);
    check("t2_done_count", 32'(jobs_done_count), 6);

    // Hung core: timeout recovery, then next jobs run
    push(7, 16'h0700, 16'h0780);
    wait_start("t3_start");
    tick();
    push(8, 16'h0800, 16'h0880);
    push(10, 16'h0A00, 16'h0A80);
    repeat (397) tick();
    check("t3_rst_before", 32'(core_rst_n), 1);
    tick();
    check("t3_rst_low1", 32'(core_rst_n), 0);
    tick();
    check("t3_rst_low2", 32'(core_rst_n), 0);
    tick();
    check("t3_rst_high", 32'(core_rst_n), 1);
    check("t3_cmp_valid", 32'(cmp_valid), 1);
    check("t3_tag", 32'(cmp_tag), 7);
    check("t3_status", 32'(cmp_status), 1);
    $display("completion tag=%0d status=%0d", cmp_tag, cmp_status);
    handshake();
    wait_start("t3_next_start");
    check("t3_next_addr", 32'(core_input_addr), 32'h0800);
    repeat (3) tick();
    core_done = 1'b1;
    wait_cmp("t3_next_cmp");
    check("t3_next_tag", 32'(cmp_tag), 8);
    check("t3_next_status", 32'(cmp_status), 0);

    // Backpressure with done held high
    s0 = start_cnt;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cmp_valid !== 1'b1 || cmp_tag !== 4'd8 || cmp_status !== 2'b00 || core_start !== 1'b0) bad++;
    end
    check("t4_hold_stable", 32'(bad), 0);
    check("t4_no_start", 32'(start_cnt - s0), 0);
    handshake();
    check("t4_cmp_drop", 32'(cmp_valid), 0);
    tick();
    check("t4_b2b_start", 32'(core_start), 1);
    check("t4_b2b_addr", 32'(core_input_addr), 32'h0A00);
    tick();
    tick();
    check("t4_stale_done", 32'(cmp_valid), 0);
    core_done = 1'b0;
    repeat (5) tick();
    check("t4_no_cmp", 32'(cmp_valid), 0);
    core_done = 1'b1;
    wait_cmp("t4_cmp");
    check("t4_tag", 32'(cmp_tag), 10);
    check("t4_status", 32'(cmp_status), 0);
    handshake();
    core_done = 1'b0;

    // Done coinciding with the last timeout cycle
    push(11, 16'h0B00, 16'h0B80);
    wait_start("t5_start");
    tick();
    repeat (399) tick();
    core_done = 1'b1;
    tick();
    check("t5_no_recover", 32'(core_rst_n), 1);
    check("t5_cmp_valid", 32'(cmp_valid), 1);
    check("t5_tag", 32'(cmp_tag), 11);
    check("t5_status", 32'(cmp_status), 0);
    $display("completion tag=%0d status=%0d", cmp_tag, cmp_status);
    handshake();
    core_done = 1'b0;
    check("t5_done_count", 32'(jobs_done_count), 10);

    // Reset mid-WAIT with two jobs queued
    push(12, 16'h0C00, 16'h0C80);
    wait_start("t6_start");
    tick();
    push(13, 16'h0D00, 16'h0D80);
    push(14, 16'h0E00, 16'h0E80);
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    check("t6_core_rst_n", 32'(core_rst_n), 0);
    check("t6_ready_in_rst", 32'(job_ready), 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("t6_idle", 32'(idle), 1);
    check("t6_job_ready", 32'(job_ready), 1);
    check("t6_done_count", 32'(jobs_done_count), 0);
    check("t6_busy", busy_cycles, 0);
    check("t6_core_rst_n_rel", 32'(core_rst_n), 1);
    s0 = start_cnt;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cmp_valid !== 1'b0 || idle !== 1'b1) bad++;
    end
    check("t6_quiet", 32'(bad), 0);
    check("t6_no_start", 32'(start_cnt - s0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
